nios_system_beat_capture: RTL

Avalon-MM slave that timestamps player key presses against the game beat clock for the rhythm game. It counts beat ticks from the interval timer's timeout/irq line and debounces the board keys. Each debounced press pushes {key mask, tick count} into a FIFO that the Nios CPU drains over a 16-bit register interface. It raises its own irq while events are pending.

---
 rtl/nios_system_beat_capture.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/nios_system_beat_capture.sv
// Beat-clock key capture: debounced key presses stamped with the beat tick count, queued for the Nios CPU.
// Optional KEY_RELEASE_EN: also queue release events (bit 31 = 1) through a one-entry holding register.

module nios_system_beat_capture_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic stable
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          s1, s2;
    logic [CW-1:0] cnt;

    // s1/s2 carry the pressed level (1 = pressed) so reset means released
    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            s1 <= ~key_n;
            s2 <= s1;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module nios_system_beat_capture #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int TICK_WIDTH      = 24,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick_in,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic [2:0]          address,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write_n,
    input  logic [15:0]         writedata,
    output logic [15:0]         readdata,
    output logic                irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef KEY_RELEASE_EN
    localparam int MW = 7;
`else
    localparam int MW = 8;
`endif

    logic [NUM_KEYS-1:0] stable, stable_prev, press_mask;
    logic [MW-1:0]       press_m;
    logic                tick_d, tick_edge;
    logic [TICK_WIDTH-1:0] tick_cnt;
    logic [23:0]         tick_ext;
    logic                capture_en, irq_en, overflow;
    logic [31:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count;
    logic                empty, full;
    logic                wr_en, rd_en, clear, pop, push_req, push_ok;
    logic [31:0]         push_data, press_entry, head;
    logic [15:0]         rd_mux;
    logic                unused_wd;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        nios_system_beat_capture_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk(clk), .reset(reset), .key_n(key_n[g]), .stable(stable[g])
        );
    end

    assign press_mask = stable & ~stable_prev;
    assign tick_edge  = tick_in & ~tick_d;
    assign tick_ext   = 24'(tick_cnt);
    assign empty      = (count == '0);
    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign head       = empty ? 32'd0 : mem[rd_ptr];
    assign wr_en      = chipselect & ~write_n;
    assign rd_en      = chipselect & read;
    assign clear      = wr_en & (address == 3'd1) & writedata[2];
    assign pop        = rd_en & (address == 3'd3) & ~empty;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign push_ok    = push_req & (~full | pop) & ~clear;
    assign unused_wd  = ^writedata[15:3];

    always_comb begin
        press_m = '0;
        press_m[NUM_KEYS-1:0] = press_mask;
    end

`ifdef KEY_RELEASE_EN
    logic [NUM_KEYS-1:0] release_mask;
    logic [MW-1:0]       release_m;
    logic [31:0]         release_entry, hold_data, hold_next;
    logic                hold_vld, hold_load;

    assign release_mask  = ~stable & stable_prev;
    assign press_entry   = {1'b0, press_m, tick_ext};
    assign release_entry = {1'b1, release_m, tick_ext};

    always_comb begin
        release_m = '0;
        release_m[NUM_KEYS-1:0] = release_mask;
    end

    // held entry goes first; a new event arriving meanwhile takes its place
    always_comb begin
        push_req  = 1'b0;
        push_data = press_entry;
        hold_load = 1'b0;
        hold_next = release_entry;
        if (hold_vld) begin
            push_req  = 1'b1;
            push_data = hold_data;
            hold_load = capture_en & ((|press_mask) | (|release_mask));
            hold_next = (|press_mask) ? press_entry : release_entry;
        end else if (|press_mask) begin
            push_req  = capture_en;
            hold_load = capture_en & (|release_mask);
        end else if (|release_mask) begin
            push_req  = capture_en;
            push_data = release_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            hold_vld <= 1'b0;
        end else begin
            hold_vld <= hold_load;
            if (hold_load) hold_data <= hold_next;
        end
    end
`else
    assign press_entry = {press_m, tick_ext};

    always_comb begin
        push_req  = capture_en & (|press_mask);
        push_data = press_entry;
    end
`endif

    always_comb begin
        case (address)
            3'd0:    rd_mux = {6'd0, 7'(count), overflow, full, empty};
            3'd1:    rd_mux = {14'd0, irq_en, capture_en};
            3'd2:    rd_mux = head[15:0];
            3'd3:    rd_mux = head[31:16];
            3'd4:    rd_mux = tick_ext[15:0];
            3'd5:    rd_mux = {8'd0, tick_ext[23:16]};
            default: rd_mux = 16'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_prev <= '0;
            tick_d      <= 1'b0;
            tick_cnt    <= '0;
            capture_en  <= 1'b0;
            irq_en      <= 1'b0;
            overflow    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            readdata    <= 16'd0;
            irq         <= 1'b0;
        end else begin
            stable_prev <= stable;
            tick_d      <= tick_in;
            irq         <= irq_en & ~empty;
            if (rd_en) readdata <= rd_mux;
            if (wr_en && address == 3'd1) begin
                capture_en <= writedata[0];
                irq_en     <= writedata[1];
            end
            if (clear) begin
                tick_cnt <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                if (tick_edge) tick_cnt <= tick_cnt + 1'b1;
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop)     rd_ptr <= rd_ptr + 1'b1;
                if (push_ok && !pop)      count <= count + 1'b1;
                else if (!push_ok && pop) count <= count - 1'b1;
            end
            if (clear || (wr_en && address == 3'd0)) overflow <= 1'b0;
            else if (push_req && full && !pop)       overflow <= 1'b1;
        end
    end
endmodule
